cordic_iter_core: RTL and testbench

- Parametrised iterative CORDIC engine performing one micro-rotation per clock.
- Supports rotation and vectoring modes, with quadrant pre-rotation so that the full ±pi angle range converges.
- Uses valid/ready handshakes on both input and output.
- Sits between the systolic-array post-processing datapath and downstream consumers; uses the shared cordic_pkg types, generalised in width and iteration count.

---
 rtl/cordic_pkg.sv | 35 +++
 rtl/cordic_atan_rom.sv | 30 +++
 rtl/cordic_iter_core.sv | 179 +++++++++++++++++
 tb/tb_cordic_iter_core.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cordic_pkg
// Brief    : Shared CORDIC types, default widths and the arctangent table.
// Revision : 1.0
// ============================================================================
package cordic_pkg;

    localparam int CORDIC_DATA_WIDTH        = 16;
    localparam int CORDIC_OUTPUT_DATA_WIDTH = CORDIC_DATA_WIDTH + 2;
    localparam int CORDIC_MAX_ITERATIONS    = 24;

    typedef enum logic {
        ROTATION = 1'b0,
        VECTOR   = 1'b1
    } cordic_func;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cordic_state;

    // atan(2^-i) as a binary angle, 2^31 == pi
    localparam logic [31:0] ATAN_TABLE [CORDIC_MAX_ITERATIONS] = '{
        32'h20000000, 32'h12E4051D, 32'h09FB385B, 32'h051111D4,
        32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
        32'h0028BE53, 32'h00145F2E, 32'h000A2F98, 32'h000517CC,
        32'h00028BE6, 32'h000145F3, 32'h0000A2F9, 32'h0000517C,
        32'h000028BE, 32'h0000145F, 32'h00000A2F, 32'h00000517,
        32'h0000028B, 32'h00000145, 32'h000000A2, 32'h00000051
    };

endpackage
`default_nettype wire

// File: rtl/cordic_atan_rom.sv
`default_nettype none
// ============================================================================
// Module   : cordic_atan_rom
// Brief    : Combinational lookup of atan(2^-idx) rounded to WIDTH bits.
// Revision : 1.0
// ============================================================================
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int WIDTH = 19
) (
    input  logic [4:0]       idx,
    output logic [WIDTH-1:0] atan
);

    localparam int c_shift = 32 - WIDTH;

    logic [31:0] w_entry;

    always_comb begin
        w_entry = '0;
        if (idx < 5'(CORDIC_MAX_ITERATIONS)) begin
            w_entry = ATAN_TABLE[idx];
        end
        // Table entries stay below 2^30, so the rounding add cannot carry out
        atan = WIDTH'((w_entry + (32'd1 << (c_shift - 1))) >> c_shift);
    end

endmodule
`default_nettype wire

// File: rtl/cordic_iter_core.sv
`default_nettype none
// ============================================================================
// Module   : cordic_iter_core
// Brief    : Iterative CORDIC, one micro-rotation per clock, rotation/vector.
// Revision : 1.0
// ============================================================================
module cordic_iter_core
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH = CORDIC_DATA_WIDTH,
    parameter int OUT_WIDTH  = CORDIC_OUTPUT_DATA_WIDTH,
    parameter int ITERATIONS = 14,
    parameter int GUARD      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [DATA_WIDTH-1:0] in_x,
    input  logic [DATA_WIDTH-1:0] in_y,
    input  logic [DATA_WIDTH-1:0] in_z,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_x,
    output logic [OUT_WIDTH-1:0]  out_y,
    output logic [OUT_WIDTH-1:0]  out_z
);

    localparam int c_xw = OUT_WIDTH + GUARD;
    localparam int c_zw = DATA_WIDTH + GUARD;
    localparam logic [4:0] c_last = 5'(ITERATIONS - 1);
    localparam logic signed [c_zw-1:0] c_half_pi = c_zw'(1) << (c_zw - 2);

    cordic_state               r_state;
    cordic_func                r_mode;
    logic [4:0]                r_cnt;
    logic                      r_in_ready;
    logic                      r_out_valid;
    logic signed [c_xw-1:0]    r_x, r_y;
    logic signed [c_zw-1:0]    r_z;
    logic [OUT_WIDTH-1:0]      r_out_x, r_out_y, r_out_z;

    logic signed [c_xw-1:0]    w_x_ext, w_y_ext, w_x0, w_y0;
    logic signed [c_zw-1:0]    w_z_ext, w_z0;
    logic signed [c_xw-1:0]    w_xs, w_ys, w_x_nx, w_y_nx;
    logic signed [c_zw-1:0]    w_z_nx;
    logic [c_zw-1:0]           w_atan;
    logic                      w_dpos;
    logic signed [OUT_WIDTH-1:0]  w_rx, w_ry;
    logic signed [DATA_WIDTH-1:0] w_rz;

    assign w_x_ext = c_xw'($signed(in_x)) <<< GUARD;
    assign w_y_ext = c_xw'($signed(in_y)) <<< GUARD;
    assign w_z_ext = c_zw'(in_z) << GUARD;

    // Quadrant fold so the residual angle lies inside the CORDIC convergence range
    always_comb begin
        w_x0 = w_x_ext;
        w_y0 = w_y_ext;
        w_z0 = w_z_ext;
        if (cordic_func'(in_mode) == ROTATION) begin
            if (in_z[DATA_WIDTH-1:DATA_WIDTH-2] == 2'b01) begin
                w_x0 = -w_y_ext;
                w_y0 = w_x_ext;
                w_z0 = w_z_ext - c_half_pi;
            end else if (in_z[DATA_WIDTH-1:DATA_WIDTH-2] == 2'b10) begin
                w_x0 = w_y_ext;
                w_y0 = -w_x_ext;
                w_z0 = w_z_ext + c_half_pi;
            end
        end else if (in_x[DATA_WIDTH-1]) begin
            if (!in_y[DATA_WIDTH-1]) begin
                w_x0 = w_y_ext;
                w_y0 = -w_x_ext;
                w_z0 = w_z_ext + c_half_pi;
            end else begin
                w_x0 = -w_y_ext;
                w_y0 = w_x_ext;
                w_z0 = w_z_ext - c_half_pi;
            end
        end
    end

    cordic_atan_rom #(
        .WIDTH (c_zw)
    ) u_atan_rom (
        .idx  (r_cnt),
        .atan (w_atan)
    );

    assign w_xs   = r_x >>> r_cnt;
    assign w_ys   = r_y >>> r_cnt;
    assign w_dpos = (r_mode == ROTATION) ? ~r_z[c_zw-1] : r_y[c_xw-1];

    always_comb begin
        if (w_dpos) begin
            w_x_nx = r_x - w_ys;
            w_y_nx = r_y + w_xs;
            w_z_nx = r_z - w_atan;
        end else begin
            w_x_nx = r_x + w_ys;
            w_y_nx = r_y - w_xs;
            w_z_nx = r_z + w_atan;
        end
    end

    if (GUARD > 0) begin : g_round
        localparam logic signed [c_xw-1:0] c_xhalf = c_xw'(1) << (GUARD - 1);
        localparam logic signed [c_zw-1:0] c_zhalf = c_zw'(1) << (GUARD - 1);
        assign w_rx = OUT_WIDTH'((w_x_nx + c_xhalf) >>> GUARD);
        assign w_ry = OUT_WIDTH'((w_y_nx + c_xhalf) >>> GUARD);
        assign w_rz = DATA_WIDTH'((w_z_nx + c_zhalf) >>> GUARD);
    end else begin : g_exact
        assign w_rx = w_x_nx;
        assign w_ry = w_y_nx;
        assign w_rz = w_z_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_mode      <= ROTATION;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_z     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_x        <= w_x0;
                        r_y        <= w_y0;
                        r_z        <= w_z0;
                        r_mode     <= cordic_func'(in_mode);
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_x   <= w_x_nx;
                    r_y   <= w_y_nx;
                    r_z   <= w_z_nx;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == c_last) begin
                        r_out_x     <= w_rx;
                        r_out_y     <= w_ry;
                        r_out_z     <= OUT_WIDTH'(w_rz);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_x     = r_out_x;
    assign out_y     = r_out_y;
    assign out_z     = r_out_z;

endmodule
`default_nettype wire

// File: tb/tb_cordic_iter_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cordic_iter_core
// Brief    : Self-checking bench for cordic_iter_core against a real-valued model.
// Revision : 1.0
// ============================================================================
module tb_cordic_iter_core;

    localparam int  DW   = 16;
    localparam int  OW   = 18;
    localparam int  ITER = 14;
    localparam int  G    = 3;
    localparam int  N    = 100;
    localparam real C_PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_mode = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid;
    logic signed [DW-1:0] in_x = '0, in_y = '0, in_z = '0;
    logic signed [OW-1:0] out_x, out_y, out_z;

    int  n_tests = 0;
    int  n_fail  = 0;
    real k_gain;

    bit s_m [N];
    int s_x [N];
    int s_y [N];
    int s_z [N];

    always #5 clk = ~clk;

    cordic_iter_core #(
        .DATA_WIDTH (DW),
        .OUT_WIDTH  (OW),
        .ITERATIONS (ITER),
        .GUARD      (G)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_z      (in_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_z     (out_z)
    );

    task automatic check_val(input string tag, input int obs, input int exp,
                             input int tol, input bit wrap);
        int d;
        n_tests++;
        d = obs - exp;
        if (wrap) begin
            d = d % 65536;
            if (d > 32767) d -= 65536;
            else if (d < -32768) d += 65536;
        end
        if (d < 0) d = -d;
        if (d > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // Ideal CORDIC result: exact trig scaled by the iteration gain
    function automatic void model(input bit m, input int x, input int y, input int z,
                                  output int ex, output int ey, output int ez,
                                  output real mag);
        real zr, ang;
        mag = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
        if (!m) begin
            zr = real'(z) * C_PI / 32768.0;
            ex = int'(k_gain * (real'(x) * $cos(zr) - real'(y) * $sin(zr)));
            ey = int'(k_gain * (real'(x) * $sin(zr) + real'(y) * $cos(zr)));
            ez = 0;
        end else begin
            ang = real'(z) + $atan2(real'(y), real'(x)) * 32768.0 / C_PI;
            ex  = int'(k_gain * mag);
            ey  = 0;
            ez  = int'(ang);
        end
    endfunction

    task automatic check_result(input string tag, input bit m, input int x, input int y,
                                input int z, input bit scaled);
        int  ex, ey, ez, txy, tz;
        real mag;
        model(m, x, y, z, ex, ey, ez, mag);
        txy = scaled ? 4 + int'(k_gain * mag / 8192.0 + 0.5) : 4;
        tz  = (scaled && m) ? 6 : 4;
        check_val({tag, "_x"}, int'(out_x), ex, txy, 1'b0);
        check_val({tag, "_y"}, int'(out_y), ey, txy, 1'b0);
        check_val({tag, "_z"}, int'(out_z), ez, tz, 1'b1);
    endtask

    task automatic do_op(input bit m, input int x, input int y, input int z, output int lat);
        int w;
        in_mode  = m;
        in_x     = 16'(x);
        in_y     = 16'(y);
        in_z     = 16'(z);
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        check_val("accept_ready", int'(in_ready), 1, 0, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check_val("result_valid", int'(out_valid), 1, 0, 1'b0);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val({tag, "_rel_ready"}, int'(in_ready), 1, 0, 1'b0);
        check_val({tag, "_rel_valid"}, int'(out_valid), 0, 0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1);
    end

    initial begin
        int  lat, tries, seen;
        real r2;

        k_gain = 1.0;
        for (int i = 0; i < ITER; i++) begin
            k_gain = k_gain * $sqrt(1.0 + 1.0 / (4.0 ** i));
        end

        for (int i = 0; i < N; i++) begin
            s_m[i] = 1'($urandom_range(0, 1));
            s_z[i] = int'($urandom_range(0, 65535)) - 32768;
            tries = 0;
            do begin
                s_x[i] = int'($urandom_range(0, 56000)) - 28000;
                s_y[i] = int'($urandom_range(0, 56000)) - 28000;
                r2 = real'(s_x[i]) * real'(s_x[i]) + real'(s_y[i]) * real'(s_y[i]);
                tries++;
            end while ((r2 < 64.0e6 || r2 > 784.0e6) && tries < 1000);
        end

        #2;
        check_val("rst_in_ready",  int'(in_ready),  0, 0, 1'b0);
        check_val("rst_out_valid", int'(out_valid), 0, 0, 1'b0);
        check_val("rst_out_x",     int'(out_x),     0, 0, 1'b0);
        check_val("rst_out_y",     int'(out_y),     0, 0, 1'b0);
        check_val("rst_out_z",     int'(out_z),     0, 0, 1'b0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("idle_in_ready", int'(in_ready), 1, 0, 1'b0);

        do_op(1'b0, 10000, 0, 0, lat);
        check_val("latency", lat, ITER + 1, 0, 1'b0);
        check_result("rot0", 1'b0, 10000, 0, 0, 1'b0);
        release_result("rot0");

        do_op(1'b0, 10000, 0, 16384, lat);
        check_result("rot90", 1'b0, 10000, 0, 16384, 1'b0);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check_val("bp_valid", int'(out_valid), 1, 0, 1'b0);
            check_val("bp_ready", int'(in_ready), 0, 0, 1'b0);
            check_result("bp", 1'b0, 10000, 0, 16384, 1'b0);
        end
        release_result("bp");

        do_op(1'b1, 10000, 10000, 0, lat);
        check_result("vec45", 1'b1, 10000, 10000, 0, 1'b0);
        release_result("vec45");

        do_op(1'b1, -10000, 1, 0, lat);
        check_result("vecpi", 1'b1, -10000, 1, 0, 1'b0);
        release_result("vecpi");

        out_ready = 1'b1;
        fork
            begin : producer
                int w;
                for (int i = 0; i < N; i++) begin
                    in_mode  = s_m[i];
                    in_x     = 16'(s_x[i]);
                    in_y     = 16'(s_y[i]);
                    in_z     = 16'(s_z[i]);
                    in_valid = 1'b1;
                    w = 0;
                    while (!in_ready && w < 100) begin
                        @(posedge clk); #1; w++;
                    end
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
            end
            begin : consumer
                int w, cyc, last;
                cyc  = 0;
                last = 0;
                for (int j = 0; j < N; j++) begin
                    w = 0;
                    while (!out_valid && w < 100) begin
                        @(posedge clk); #1; cyc++; w++;
                    end
                    check_val("s_valid", int'(out_valid), 1, 0, 1'b0);
                    if (j > 0) check_val("s_period", cyc - last, ITER + 2, 0, 1'b0);
                    last = cyc;
                    check_result("s", s_m[j], s_x[j], s_y[j], s_z[j], 1'b1);
                    @(posedge clk); #1; cyc++;
                end
            end
        join
        out_ready = 1'b0;

        in_mode  = 1'b0;
        in_x     = 16'(12000);
        in_y     = -16'(5000);
        in_z     = 16'(3000);
        in_valid = 1'b1;
        lat = 0;
        while (!in_ready && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_val("arst_out_valid", int'(out_valid), 0, 0, 1'b0);
        check_val("arst_in_ready",  int'(in_ready),  0, 0, 1'b0);
        check_val("arst_out_x",     int'(out_x),     0, 0, 1'b0);
        check_val("arst_out_y",     int'(out_y),     0, 0, 1'b0);
        check_val("arst_out_z",     int'(out_z),     0, 0, 1'b0);
        #10 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("arst_idle_ready", int'(in_ready), 1, 0, 1'b0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        check_val("no_stale_result", seen, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
